// File: rtl/cpu_run_ctrl_if.sv
// Program-load stream between a loader (master) and the run controller (slave).
interface cpu_run_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Loads a program into a local instruction store, then runs a CPU against it
// until the PC leaves the program (plus a pipeline drain) or a cycle limit hits.
module cpu_run_ctrl #(
  parameter int NMEM      = 64,
  parameter int AW        = $clog2(NMEM),
  parameter int DRAIN_CYC = 4,
  parameter int CYC_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  cpu_run_ctrl_if.slave      ld,
  input  logic               run_start,
  input  logic [CYC_W-1:0]   cycle_limit,
  input  logic [31:0]        pc,
  output logic [31:0]        inst,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycles,
  output logic [AW:0]        prog_len
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic            ld_ready_q;
  logic [DW-1:0]   drain_cnt;
  logic [31:0]     mem [NMEM];

  logic            transfer;
  logic            pc_in_prog;
  logic            executing;
  logic [CYC_W:0]  cycles_inc;
  logic            hit_limit;
  logic [CYC_W-1:0] cycles_next;
  logic            unused_pc;

  assign ld.ld_ready  = ld_ready_q;
  assign transfer     = ld.ld_valid && ld_ready_q;
  assign pc_in_prog   = pc[31:2] < 30'(prog_len);
  assign executing    = (state == RUN) || (state == DRAIN);
  assign cycles_inc   = {1'b0, cycles} + (CYC_W+1)'(1);
  assign hit_limit    = (cycle_limit != '0) && (cycles_inc >= {1'b0, cycle_limit});
  assign cycles_next  = cycles_inc[CYC_W] ? cycles : cycles_inc[CYC_W-1:0];
  assign unused_pc    = ^pc[1:0];

  // Words beyond prog_len read as NOP even though stale contents remain in mem.
  assign inst = (executing && pc_in_prog) ? mem[pc[AW+1:2]] : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (transfer) begin
      mem[prog_len[AW-1:0]] <= ld.ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      ld_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycles     <= '0;
      prog_len   <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            prog_len   <= '0;
            ld_ready_q <= 1'b1;
            busy       <= 1'b1;
          end else if (run_start && prog_len != '0) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            busy      <= 1'b1;
            cycles    <= '0;
          end
        end

        LOAD: begin
          if (transfer) begin
            prog_len <= prog_len + (AW+1)'(1);
            if (ld.ld_last || prog_len == (AW+1)'(NMEM-1)) begin
              state      <= IDLE;
              ld_ready_q <= 1'b0;
              busy       <= 1'b0;
            end
          end
        end

        RUN: begin
          cycles <= cycles_next;
          if (hit_limit) begin
            state     <= DONE;
            timeout   <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b1;
          end else if (!pc_in_prog) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYC-1);
          end
        end

        // A branch back into the program resumes RUN; the timeout still wins.
        DRAIN: begin
          cycles <= cycles_next;
          if (hit_limit) begin
            state     <= DONE;
            timeout   <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b1;
          end else if (pc_in_prog) begin
            state <= RUN;
          end else if (drain_cnt == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end

        DONE: begin
          if (load_start) begin
            state      <= LOAD;
            prog_len   <= '0;
            ld_ready_q <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end else if (run_start) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycles    <= '0;
          end
        end

        default: begin
          state      <= IDLE;
          cpu_reset  <= 1'b1;
          ld_ready_q <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed-vector bench for cpu_run_ctrl: load, run/drain, timeout, branch-back, full load, reset abort.
module tb_cpu_run_ctrl;

  localparam int NMEM  = 64;
  localparam int AW    = $clog2(NMEM);
  localparam int CYC_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_start;
  logic             run_start;
  logic [CYC_W-1:0] cycle_limit;
  logic [31:0]      pc;
  logic [31:0]      inst;
  logic             cpu_reset;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CYC_W-1:0] cycles;
  logic [AW:0]      prog_len;

  int tests_run    = 0;
  int tests_failed = 0;

  cpu_run_ctrl_if ld_if ();

  cpu_run_ctrl #(.NMEM(NMEM), .DRAIN_CYC(4), .CYC_W(CYC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .ld          (ld_if),
    .run_start   (run_start),
    .cycle_limit (cycle_limit),
    .pc          (pc),
    .inst        (inst),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycles      (cycles),
    .prog_len    (prog_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_run();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pc = 32'h0;
    tick();
    #1;
    tests_run++; if (cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cpu_reset: got %0b expected 1", cpu_reset); end
    tests_run++; if (ld_if.ld_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ld_ready: got %0b expected 0", ld_if.ld_ready); end
    tests_run++; if ({busy, done, timeout} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, timeout}); end
    tests_run++; if (cycles !== '0) begin tests_failed++; $display("[TB] FAIL reset_cycles: got %0d expected 0", cycles); end
    tests_run++; if (prog_len !== '0) begin tests_failed++; $display("[TB] FAIL reset_prog_len: got %0d expected 0", prog_len); end
    tests_run++; if (inst !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_inst: got %h expected 0", inst); end
    reset = 1'b0;
    tick();
    // Empty program: run_start must be ignored.
    pulse_run();
    tests_run++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL run_empty_ignored: got busy=%0b cpu_reset=%0b expected busy=0 cpu_reset=1", busy, cpu_reset); end
  endtask

  task automatic test_load_three();
    logic [31:0] words [3];
    words[0] = 32'hDEAD_0000;
    words[1] = 32'hBEEF_0004;
    words[2] = 32'hCAFE_0008;
    pulse_load();
    tests_run++; if (ld_if.ld_ready !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_enter: got ready=%0b busy=%0b expected 1 1", ld_if.ld_ready, busy); end
    for (int i = 0; i < 3; i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = words[i];
      ld_if.ld_last  = (i == 2);
      tick();
      ld_if.ld_valid = 1'b0;
      ld_if.ld_last  = 1'b0;
      if (i < 2) begin
        tick();
        tests_run++; if (prog_len !== (AW+1)'(i+1)) begin tests_failed++; $display("[TB] FAIL load3_len_%0d: got %0d expected %0d", i, prog_len, i+1); end
      end
    end
    tests_run++; if (prog_len !== (AW+1)'(3)) begin tests_failed++; $display("[TB] FAIL load3_prog_len: got %0d expected 3", prog_len); end
    tests_run++; if (busy !== 1'b0 || ld_if.ld_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL load3_idle: got busy=%0b ready=%0b expected 0 0", busy, ld_if.ld_ready); end
  endtask

  task automatic test_run_drain();
    logic [31:0] exp_inst [4];
    exp_inst[0] = 32'hDEAD_0000;
    exp_inst[1] = 32'hBEEF_0004;
    exp_inst[2] = 32'hCAFE_0008;
    exp_inst[3] = 32'h0;
    cycle_limit = '0;
    pc = 32'h0;
    pulse_run();
    tests_run++; if (cpu_reset !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL run_enter: got cpu_reset=%0b busy=%0b expected 0 1", cpu_reset, busy); end
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      #1;
      tests_run++; if (inst !== exp_inst[i]) begin tests_failed++; $display("[TB] FAIL run_inst_pc%0d: got %h expected %h", i*4, inst, exp_inst[i]); end
      tick();
    end
    pc = 32'd16;
    for (int i = 0; i < 3; i++) tick();
    tests_run++; if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_still_busy: got busy=%0b done=%0b expected 1 0", busy, done); end
    tick();
    tests_run++; if (done !== 1'b1 || timeout !== 1'b0 || cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_done: got done=%0b timeout=%0b cpu_reset=%0b expected 1 0 1", done, timeout, cpu_reset); end
    tests_run++; if (cycles !== CYC_W'(8)) begin tests_failed++; $display("[TB] FAIL drain_cycles: got %0d expected 8", cycles); end
  endtask

  task automatic test_timeout();
    cycle_limit = CYC_W'(5);
    pc = 32'h0;
    pulse_run();
    tests_run++; if (done !== 1'b0 || cycles !== '0) begin tests_failed++; $display("[TB] FAIL rerun_clear: got done=%0b cycles=%0d expected 0 0", done, cycles); end
    for (int i = 0; i < 4; i++) tick();
    tests_run++; if (busy !== 1'b1 || cycles !== CYC_W'(4)) begin tests_failed++; $display("[TB] FAIL timeout_pre: got busy=%0b cycles=%0d expected 1 4", busy, cycles); end
    tick();
    tests_run++; if (done !== 1'b1 || timeout !== 1'b1 || cycles !== CYC_W'(5)) begin tests_failed++; $display("[TB] FAIL timeout_hit: got done=%0b timeout=%0b cycles=%0d expected 1 1 5", done, timeout, cycles); end
    tests_run++; if (inst !== 32'h0) begin tests_failed++; $display("[TB] FAIL done_inst_nop: got %h expected 0", inst); end
    tick();
    tests_run++; if (timeout !== 1'b1 || cycles !== CYC_W'(5)) begin tests_failed++; $display("[TB] FAIL timeout_sticky: got timeout=%0b cycles=%0d expected 1 5", timeout, cycles); end
  endtask

  task automatic test_branch_back();
    cycle_limit = '0;
    pc = 32'd12;
    pulse_run();
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL rerun_timeout_clear: got %0b expected 0", timeout); end
    for (int i = 0; i < 3; i++) tick();
    pc = 32'd4;
    #1;
    tests_run++; if (inst !== 32'hBEEF_0004) begin tests_failed++; $display("[TB] FAIL drain_inst_back: got %h expected beef0004", inst); end
    tick();
    pc = 32'd12;
    tick();
    for (int i = 0; i < 3; i++) tick();
    tests_run++; if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_reload: got busy=%0b done=%0b expected 1 0", busy, done); end
    tick();
    tests_run++; if (done !== 1'b1 || cycles !== CYC_W'(9)) begin tests_failed++; $display("[TB] FAIL branch_done: got done=%0b cycles=%0d expected 1 9", done, cycles); end
  endtask

  task automatic test_load_full();
    pulse_load();
    for (int i = 0; i < NMEM; i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = 32'hC0DE_0000 + 32'(i);
      ld_if.ld_last  = 1'b0;
      tests_run++; if (ld_if.ld_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_ready_%0d: got %0b expected 1", i, ld_if.ld_ready); end
      tick();
    end
    tests_run++; if (prog_len !== (AW+1)'(NMEM) || ld_if.ld_ready !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_exit: got len=%0d ready=%0b busy=%0b expected %0d 0 0", prog_len, ld_if.ld_ready, busy, NMEM); end
    tick();
    ld_if.ld_valid = 1'b0;
    tests_run++; if (prog_len !== (AW+1)'(NMEM)) begin tests_failed++; $display("[TB] FAIL full_no_extra: got %0d expected %0d", prog_len, NMEM); end
    cycle_limit = '0;
    pc = 32'(4 * (NMEM - 1));
    pulse_run();
    tests_run++; if (inst !== 32'hC0DE_0000 + 32'(NMEM - 1)) begin tests_failed++; $display("[TB] FAIL full_last_word: got %h expected %h", inst, 32'hC0DE_0000 + 32'(NMEM - 1)); end
    pc = 32'(4 * NMEM);
    #1;
    tests_run++; if (inst !== 32'h0) begin tests_failed++; $display("[TB] FAIL full_past_end: got %h expected 0", inst); end
    for (int i = 0; i < 20 && !done; i++) tick();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_run_done: got %0b expected 1 within 20 cycles", done); end
  endtask

  task automatic test_reset_mid_run();
    pc = 32'h0;
    pulse_run();
    tick();
    tests_run++; if (cpu_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun_running: got %0b expected 0", cpu_reset); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (cpu_reset !== 1'b1 || prog_len !== '0 || busy !== 1'b0 || cycles !== '0) begin tests_failed++; $display("[TB] FAIL midrun_abort: got cpu_reset=%0b len=%0d busy=%0b cycles=%0d expected 1 0 0 0", cpu_reset, prog_len, busy, cycles); end
    reset = 1'b0;
    tick();
    pulse_run();
    tests_run++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrun_run_ignored: got busy=%0b cpu_reset=%0b expected 0 1", busy, cpu_reset); end
    load_start = 1'b1;
    run_start  = 1'b1;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
    tests_run++; if (ld_if.ld_ready !== 1'b1 || cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL both_starts_load: got ready=%0b cpu_reset=%0b expected 1 1", ld_if.ld_ready, cpu_reset); end
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 32'h1234_5678;
    ld_if.ld_last  = 1'b1;
    tick();
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    tests_run++; if (prog_len !== (AW+1)'(1) || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reload_one: got len=%0d busy=%0b expected 1 0", prog_len, busy); end
  endtask

  initial begin
    reset          = 1'b1;
    load_start     = 1'b0;
    run_start      = 1'b0;
    cycle_limit    = '0;
    pc             = 32'h0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 32'h0;
    ld_if.ld_last  = 1'b0;
    test_reset();
    test_load_three();
    test_run_drain();
    test_timeout();
    test_branch_back();
    test_load_full();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
